// File: rtl/mux_arb_nx1.sv
// N-to-1 registered multiplexer/arbiter: fixed select (mode=0) or round-robin (mode=1).
// Optional transfer counter output enabled by defining MUX_ARB_STATS_EN.
module mux_arb_nx1 #(
   parameter  int WIDTH = 32,
   parameter  int N     = 3,
   localparam int SEL_W = (N > 2) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 mode,
   input  logic [SEL_W-1:0]     S,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SEL_W-1:0]     grant
`ifdef MUX_ARB_STATS_EN
   ,
   output logic [15:0]          xfer_count
`endif
);

   logic              w_load_ok;
   logic [SEL_W-1:0]  w_sel;
   logic              w_sel_ok;
   logic [SEL_W-1:0]  w_idx;
   logic              w_xfer;
   logic [WIDTH-1:0]  w_sel_data;

   logic [SEL_W-1:0]  r_ptr;
   logic              r_out_valid;
   logic [WIDTH-1:0]  r_out_data;
   logic [SEL_W-1:0]  r_grant;

   assign w_load_ok = !r_out_valid || out_ready;

   // Round-robin scans downward so the last hit (closest to ptr+1) wins.
   always_comb begin
      w_sel    = '0;
      w_sel_ok = 1'b0;
      w_idx    = '0;
      if (!mode) begin
         if (int'(S) < N) begin
            w_sel    = S;
            w_sel_ok = 1'b1;
         end
      end else begin
         for (int k = N; k >= 1; k--) begin
            w_idx = SEL_W'((int'(r_ptr) + k) % N);
            if (in_valid[w_idx]) begin
               w_sel    = w_idx;
               w_sel_ok = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (w_sel == SEL_W'(i)) w_sel_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      in_ready = '0;
      if (!reset && w_sel_ok && w_load_ok) in_ready[w_sel] = 1'b1;
   end

   assign w_xfer = !reset && w_sel_ok && w_load_ok && in_valid[w_sel];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_grant     <= '0;
         r_ptr       <= SEL_W'(N - 1);
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_sel_data;
         r_grant     <= w_sel;
         if (mode) r_ptr <= w_sel;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign grant     = r_grant;

`ifdef MUX_ARB_STATS_EN
   logic [15:0] r_xfer_count;

   always_ff @(posedge clk) begin
      if (reset)                                   r_xfer_count <= '0;
      else if (w_xfer && r_xfer_count != 16'hFFFF) r_xfer_count <= r_xfer_count + 16'd1;
   end

   assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Self-checking bench for mux_arb_nx1 (N=3, WIDTH=8): directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_mux_arb_nx1;
   localparam int N     = 3;
   localparam int WIDTH = 8;

   logic          clk;
   logic          reset;
   logic [23:0]   in_data;
   logic [2:0]    in_valid;
   logic [2:0]    in_ready;
   logic          mode;
   logic [1:0]    S;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    grant;
`ifdef MUX_ARB_STATS_EN
   logic [15:0]   xfer_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic          m_ov;
   logic [7:0]    m_data;
   int            m_grant;
   int            m_ptr;
   int            m_cnt;

   mux_arb_nx1 #(.WIDTH(WIDTH), .N(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .mode       (mode),
      .S          (S),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .grant      (grant)
`ifdef MUX_ARB_STATS_EN
      ,
      .xfer_count (xfer_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Which channel the model would grant now, and whether it transfers.
   task automatic model_ready(output logic [2:0] rdy, output int acc);
      int  cand;
      bit  lok;
      rdy  = 3'b000;
      acc  = -1;
      cand = -1;
      if (reset !== 1'b1) begin
         lok = !m_ov || out_ready;
         if (mode == 1'b0) begin
            if (int'(S) < N) cand = int'(S);
         end else begin
            for (int k = 1; k <= N; k++)
               if (cand < 0 && in_valid[(m_ptr + k) % N]) cand = (m_ptr + k) % N;
         end
         if (cand >= 0 && lok) begin
            rdy[cand] = 1'b1;
            if (in_valid[cand]) acc = cand;
         end
      end
   endtask

   task automatic tick();
      logic [2:0] rdy;
      int         acc;
      model_ready(rdy, acc);
      @(posedge clk);
      if (reset === 1'b1) begin
         m_ov = 1'b0; m_data = 8'h00; m_grant = 0; m_ptr = N - 1; m_cnt = 0;
      end else if (acc >= 0) begin
         m_ov    = 1'b1;
         m_data  = in_data[acc*WIDTH +: WIDTH];
         m_grant = acc;
         if (mode) m_ptr = acc;
         if (m_cnt < 65535) m_cnt++;
      end else if (m_ov && out_ready) begin
         m_ov = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; mode = 1'b0; S = 2'd0; in_valid = 3'b111;
      in_data = {8'hCC, 8'hBB, 8'hAA}; out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 3'b000) begin
         n_fail++; $display("FAIL reset_in_ready actual=%b required=000", in_ready);
      end
      tick(); tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || grant !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_outputs actual ov=%b data=%h grant=%0d required ov=0 data=00 grant=0",
                  out_valid, out_data, grant);
      end
   endtask

   task automatic test_fixed();
      reset = 1'b0; mode = 1'b0; S = 2'd1; in_valid = 3'b111;
      in_data = {8'hCC, 8'hBB, 8'hAA}; out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 3'b010) begin
         n_fail++; $display("FAIL fixed_in_ready actual=%b required=010", in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hBB || grant !== 2'd1) begin
         n_fail++;
         $display("FAIL fixed_select actual ov=%b data=%h grant=%0d required ov=1 data=bb grant=1",
                  out_valid, out_data, grant);
      end
      S = 2'd3;
      #1;
      n_checks++;
      if (in_ready !== 3'b000) begin
         n_fail++; $display("FAIL fixed_s_oob_ready actual=%b required=000", in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'hBB || grant !== 2'd1) begin
         n_fail++;
         $display("FAIL fixed_s_oob_drain actual ov=%b data=%h grant=%0d required ov=0 data=bb grant=1",
                  out_valid, out_data, grant);
      end
   endtask

   task automatic test_rr_fair();
      int exp_g[6] = '{0, 1, 2, 0, 1, 2};
      mode = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || int'(grant) != exp_g[c]) begin
            n_fail++;
            $display("FAIL rr_fair[%0d] actual ov=%b grant=%0d required ov=1 grant=%0d",
                     c, out_valid, grant, exp_g[c]);
         end
      end
   endtask

   task automatic test_rr_skip();
      in_valid = 3'b010;
      tick();
      n_checks++;
      if (grant !== 2'd1 || out_data !== 8'hBB) begin
         n_fail++; $display("FAIL rr_skip actual grant=%0d data=%h required grant=1 data=bb", grant, out_data);
      end
      in_valid = 3'b001;
      tick();
      n_checks++;
      if (grant !== 2'd0 || out_data !== 8'hAA) begin
         n_fail++; $display("FAIL rr_wrap actual grant=%0d data=%h required grant=0 data=aa", grant, out_data);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; in_valid = 3'b111; mode = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (in_ready !== 3'b000) begin
            n_fail++; $display("FAIL bp_in_ready[%0d] actual=%b required=000", c, in_ready);
         end
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 8'hAA || grant !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d] actual ov=%b data=%h grant=%0d required ov=1 data=aa grant=0",
                     c, out_valid, out_data, grant);
         end
      end
      out_ready = 1'b1; in_valid = 3'b001; in_data[7:0] = 8'h5A;
      #1;
      n_checks++;
      if (in_ready !== 3'b001) begin
         n_fail++; $display("FAIL bp_release_ready actual=%b required=001", in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h5A || grant !== 2'd0) begin
         n_fail++;
         $display("FAIL bp_replace actual ov=%b data=%h grant=%0d required ov=1 data=5a grant=0",
                  out_valid, out_data, grant);
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || grant !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid actual ov=%b data=%h grant=%0d required ov=0 data=00 grant=0",
                  out_valid, out_data, grant);
      end
      reset = 1'b0; mode = 1'b1; in_valid = 3'b111; in_data = {8'hCC, 8'hBB, 8'hAA};
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || grant !== 2'd0 || out_data !== 8'hAA) begin
         n_fail++;
         $display("FAIL reset_first_grant actual ov=%b grant=%0d data=%h required ov=1 grant=0 data=aa",
                  out_valid, grant, out_data);
      end
   endtask

   task automatic test_random();
      logic [2:0] rdy;
      int         acc;
      for (int c = 0; c < 400; c++) begin
         reset     = ($urandom_range(0, 39) == 0);
         mode      = 1'($urandom_range(0, 1));
         S         = 2'($urandom_range(0, 3));
         in_valid  = 3'($urandom_range(0, 7));
         in_data   = 24'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         model_ready(rdy, acc);
         n_checks++;
         if (in_ready !== rdy) begin
            n_fail++; $display("FAIL rand_in_ready[%0d] actual=%b required=%b", c, in_ready, rdy);
         end
         tick();
         n_checks++;
         if (out_valid !== m_ov || out_data !== m_data || int'(grant) != m_grant) begin
            n_fail++;
            $display("FAIL rand_out[%0d] actual ov=%b data=%h grant=%0d required ov=%b data=%h grant=%0d",
                     c, out_valid, out_data, grant, m_ov, m_data, m_grant);
         end
`ifdef MUX_ARB_STATS_EN
         n_checks++;
         if (int'(xfer_count) != m_cnt) begin
            n_fail++; $display("FAIL rand_count[%0d] actual=%0d required=%0d", c, xfer_count, m_cnt);
         end
`endif
      end
      reset = 1'b0;
   endtask

`ifdef MUX_ARB_STATS_EN
   task automatic test_stats();
      reset = 1'b1;
      tick();
      reset = 1'b0; mode = 1'b0; S = 2'd0; in_valid = 3'b001; out_ready = 1'b1;
      for (int c = 0; c < 5; c++) tick();
      in_valid = 3'b000;
      tick();
      n_checks++;
      if (xfer_count !== 16'd5) begin
         n_fail++; $display("FAIL stats_count actual=%0d required=5", xfer_count);
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if (xfer_count !== 16'd0) begin
         n_fail++; $display("FAIL stats_reset actual=%0d required=0", xfer_count);
      end
      reset = 1'b0;
   endtask
`endif

   initial begin
      m_ov = 1'b0; m_data = 8'h00; m_grant = 0; m_ptr = N - 1; m_cnt = 0;
      test_reset();
      test_fixed();
      test_rr_fair();
      test_rr_skip();
      test_backpressure();
      test_reset_mid();
      test_random();
`ifdef MUX_ARB_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_arb_nx1.md
MUX_ARB_NX1 -- requirements
Module: mux_arb_nx1

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per channel.
REQ-002 SHALL have parameter N, default 3, number of input channels (legal range 2..16).
REQ-003 SHALL have localparam SEL_W = max(1, clog2(N)), select/grant width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  N  per-channel data valid.
REQ-008 SHALL have port in_ready  output  N  per-channel accept; combinational.
REQ-009 SHALL have port mode  input  1  0 = fixed select via S, 1 = round-robin.
REQ-010 SHALL have port S  input  SEL_W  channel select, used when mode=0.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port grant  output  SEL_W  index of channel that supplied current out_data.

Function
REQ-015 SHALL define a transfer on channel i as in_valid[i] && in_ready[i] at a rising edge; a transfer on the output as out_valid && out_ready.
REQ-016 SHALL define load_ok = !out_valid || out_ready; no channel receives in_ready while load_ok=0.
REQ-017 SHALL, with mode=0 and S<N, assert in_ready[S]=load_ok and all other in_ready bits 0.
REQ-018 SHALL, with mode=0 and S>=N, deassert all in_ready and accept nothing.
REQ-019 SHALL, with mode=1, select the first channel with in_valid set, searching from ptr+1 upward with wrap modulo N; in_ready asserted only for that channel, gated by load_ok.
REQ-020 SHALL update ptr to the accepted channel index only on an input transfer in mode=1; ptr unchanged otherwise, including in mode=0.
REQ-021 SHALL, on an input transfer, load out_data, set out_valid=1 and grant=accepted index on the same edge; latency input transfer to out_valid = 1 cycle.
REQ-022 SHALL, on an output transfer with no input transfer, clear out_valid; out_data and grant hold.
REQ-023 SHALL, on simultaneous output and input transfer, keep out_valid=1 and replace out_data/grant (full throughput, one word per cycle).
REQ-024 SHALL hold out_data and grant stable while out_valid=1 and out_ready=0.
REQ-025 SHALL apply mode or S changes to the next arbitration only; a held output word is never altered.
REQ-026 SHALL accept at most one input per cycle.

Reset
REQ-027 SHALL, while reset=1 at a rising edge, set out_valid=0, out_data=0, grant=0, ptr=N-1 (channel 0 highest first priority).
REQ-028 SHALL force in_ready to all 0 while reset=1; a word in flight at reset is discarded.

Configuration
REQ-029 SHALL, when MUX_ARB_STATS_EN is defined, add output xfer_count (16 bits) counting input transfers, reset to 0, saturating at 16'hFFFF.
REQ-030 SHALL, when MUX_ARB_STATS_EN is undefined, omit xfer_count and its logic; all other behaviour identical.

Verification (N=3, WIDTH=8)
REQ-031 SHALL cover fixed select: mode=0, S=1, in_data={8'hCC,8'hBB,8'hAA}, in_valid=3'b111, out_ready=1 -> next cycle out_data=8'hBB, grant=1, out_valid=1; S=2'b11 -> in_ready=0, out_valid falls after drain.
REQ-032 SHALL cover round-robin fairness: mode=1, in_valid=3'b111, out_ready=1 for 6 cycles -> grant sequence 0,1,2,0,1,2.
REQ-033 SHALL cover round-robin skip and wrap: after grant=2, in_valid=3'b010 -> grant=1; then in_valid=3'b001 -> grant=0.
REQ-034 SHALL cover backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0, out_data and grant unchanged; out_ready=1 with in_valid[0] -> simultaneous replace, out_valid stays 1.
REQ-035 SHALL cover reset mid-operation: reset=1 with out_valid=1 -> next cycle out_valid=0, out_data=0, grant=0; first mode=1 grant with in_valid=3'b111 is 0.
REQ-036 SHALL cover stats (MUX_ARB_STATS_EN defined): 5 input transfers -> xfer_count=5; reset -> 0.
